// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer/flag controller of a dual-clock FIFO, entirely in the W_CLK domain.
// Optional sticky overflow flag W_OVF is built when WR_OVF_FLAG_EN is defined.
module async_fifo_wr_ctrl #(
  parameter int B_WIDTH     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 1
) (
  input  logic               W_CLK,
  input  logic               W_RST,
  input  logic               W_INC,
  input  logic [B_WIDTH:0]   G_rptr,
  output logic [B_WIDTH:0]   G_wptr,
  output logic [B_WIDTH-1:0] W_addr,
  output logic               W_EN,
  output logic               W_FULL,
  output logic               W_ALMOST_FULL,
  output logic [B_WIDTH:0]   W_LEVEL
`ifdef WR_OVF_FLAG_EN
  ,
  output logic               W_OVF
`endif
);

  localparam logic [B_WIDTH:0] DEPTH  = {1'b1, {B_WIDTH{1'b0}}};
  localparam logic [B_WIDTH:0] ONE    = {{B_WIDTH{1'b0}}, 1'b1};
  localparam logic [B_WIDTH:0] AF_LIM = AF_MARGIN[B_WIDTH:0];

  logic [B_WIDTH:0] wbin;
  logic [B_WIDTH:0] wgray;
  logic [B_WIDTH:0] sync_q [SYNC_STAGES];
  logic [B_WIDTH:0] rsync;
  logic [B_WIDTH:0] rbin;
  logic [B_WIDTH:0] free_slots;

  // Handshake: the producer raises W_INC; a write is taken on the edge where
  // W_EN is high (W_INC & ~W_FULL, never during reset). Refused requests are dropped.
  assign W_EN   = W_INC & ~W_FULL & ~W_RST;
  assign W_addr = wbin[B_WIDTH-1:0];
  assign wgray  = wbin ^ (wbin >> 1);
  assign rsync  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      wbin   <= '0;
      G_wptr <= '0;
    end else begin
      if (W_INC & ~W_FULL) wbin <= wbin + ONE;
      G_wptr <= wgray;
    end
  end

  // Plain flop chain: the Gray read pointer changes one bit at a time, so no logic between stages.
  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= G_rptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    rbin          = '0;
    rbin[B_WIDTH] = rsync[B_WIDTH];
    for (int i = B_WIDTH - 1; i >= 0; i--) rbin[i] = rbin[i+1] ^ rsync[i];
  end

  // Full when the write pointer is one lap ahead of the (possibly stale) read pointer.
  assign W_FULL        = (wgray == {~rsync[B_WIDTH:B_WIDTH-1], rsync[B_WIDTH-2:0]});
  assign W_LEVEL       = wbin - rbin;
  assign free_slots    = DEPTH - W_LEVEL;
  assign W_ALMOST_FULL = (free_slots <= AF_LIM);

`ifdef WR_OVF_FLAG_EN
  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) W_OVF <= 1'b0;
    else if (W_INC & W_FULL) W_OVF <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl (B_WIDTH=3, SYNC_STAGES=2, AF_MARGIN=1).
module tb_async_fifo_wr_ctrl;

  logic       W_CLK;
  logic       W_RST;
  logic       W_INC;
  logic [3:0] G_rptr;
  logic [3:0] G_wptr;
  logic [2:0] W_addr;
  logic       W_EN;
  logic       W_FULL;
  logic       W_ALMOST_FULL;
  logic [3:0] W_LEVEL;
`ifdef WR_OVF_FLAG_EN
  logic       W_OVF;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_wb;
  logic [3:0] rs1, rs2;

  async_fifo_wr_ctrl #(.B_WIDTH(3), .SYNC_STAGES(2), .AF_MARGIN(1)) dut (
    .W_CLK(W_CLK),
    .W_RST(W_RST),
    .W_INC(W_INC),
    .G_rptr(G_rptr),
    .G_wptr(G_wptr),
    .W_addr(W_addr),
    .W_EN(W_EN),
    .W_FULL(W_FULL),
    .W_ALMOST_FULL(W_ALMOST_FULL),
    .W_LEVEL(W_LEVEL)
`ifdef WR_OVF_FLAG_EN
    ,
    .W_OVF(W_OVF)
`endif
  );

  initial begin
    W_CLK = 1'b0;
    forever #5 W_CLK = ~W_CLK;
  end

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge W_CLK);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_addr"},  32'(W_addr), 32'd0);
    chk({tag, "_gwptr"}, 32'(G_wptr), 32'd0);
    chk({tag, "_level"}, 32'(W_LEVEL), 32'd0);
    chk({tag, "_full"},  32'(W_FULL), 32'd0);
    chk({tag, "_af"},    32'(W_ALMOST_FULL), 32'd0);
  endtask

  initial begin
    W_RST  = 1'b1;
    W_INC  = 1'b1;
    G_rptr = 4'd0;
    #1;
    chk("rst_en_blocked", 32'(W_EN), 32'd0);
    tick();
    tick();
    W_INC = 1'b0;
    W_RST = 1'b0;
    #1;
    chk_idle("after_rst");
    chk("after_rst_en", 32'(W_EN), 32'd0);
`ifdef WR_OVF_FLAG_EN
    chk("after_rst_ovf", 32'(W_OVF), 32'd0);
`endif

    // Fill all eight slots with the read pointer parked at zero.
    W_INC = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_addr",  32'(W_addr), 32'(i));
      chk("fill_en",    32'(W_EN), 32'd1);
      chk("fill_level", 32'(W_LEVEL), 32'(i));
      chk("fill_af",    32'(W_ALMOST_FULL), (i == 7) ? 32'd1 : 32'd0);
      chk("fill_full",  32'(W_FULL), 32'd0);
      tick();
    end
    #1;
    chk("full_flag",   32'(W_FULL), 32'd1);
    chk("full_level",  32'(W_LEVEL), 32'd8);
    chk("full_af",     32'(W_ALMOST_FULL), 32'd1);
    chk("full_addr",   32'(W_addr), 32'd0);
    chk("full_gwptr0", 32'(G_wptr), 32'(4'b0100));

    // Keep pushing while full: every request must be refused.
    for (int i = 0; i < 3; i++) begin
      chk("ovw_en",    32'(W_EN), 32'd0);
      tick();
      #1;
      chk("ovw_addr",  32'(W_addr), 32'd0);
      chk("ovw_level", 32'(W_LEVEL), 32'd8);
      chk("ovw_full",  32'(W_FULL), 32'd1);
      chk("ovw_gwptr", 32'(G_wptr), 32'(4'b1100));
`ifdef WR_OVF_FLAG_EN
      chk("ovw_ovf",   32'(W_OVF), 32'd1);
`endif
    end

    // One read seen by the write side only after two edges.
    W_INC  = 1'b0;
    G_rptr = 4'b0001;
    tick();
    #1;
    chk("rd_lag_full",  32'(W_FULL), 32'd1);
    chk("rd_lag_level", 32'(W_LEVEL), 32'd8);
    tick();
    #1;
    chk("rd_seen_full",  32'(W_FULL), 32'd0);
    chk("rd_seen_level", 32'(W_LEVEL), 32'd7);
    chk("rd_seen_af",    32'(W_ALMOST_FULL), 32'd1);
    W_INC = 1'b1;
    #1;
    chk("refill_en",   32'(W_EN), 32'd1);
    chk("refill_addr", 32'(W_addr), 32'd0);
    tick();
    W_INC = 1'b0;
    #1;
    chk("refill_full",  32'(W_FULL), 32'd1);
    chk("refill_addr2", 32'(W_addr), 32'd1);
`ifdef WR_OVF_FLAG_EN
    chk("refill_ovf_sticky", 32'(W_OVF), 32'd1);
`endif

    // Reader catches up, then tracks the writer across the pointer wrap.
    exp_wb = 4'd9;
    G_rptr = b2g(4'd9);
    tick();
    tick();
    #1;
    chk("drained_level", 32'(W_LEVEL), 32'd0);
    rs1 = b2g(4'd9);
    rs2 = b2g(4'd9);
    W_INC = 1'b1;
    for (int i = 0; i < 20; i++) begin
      G_rptr = b2g(exp_wb);
      #1;
      chk("trk_en",    32'(W_EN), 32'd1);
      chk("trk_full",  32'(W_FULL), 32'd0);
      chk("trk_addr",  32'(W_addr), 32'(exp_wb[2:0]));
      chk("trk_level", 32'(W_LEVEL), 32'(4'(exp_wb - g2b(rs2))));
      rs2 = rs1;
      rs1 = G_rptr;
      tick();
      exp_wb = exp_wb + 4'd1;
      chk("trk_gwptr", 32'(G_wptr), 32'(b2g(exp_wb - 4'd1)));
      if (exp_wb == 4'd0) chk("wrap_gwptr_hi", 32'(G_wptr), 32'(4'b1000));
      if (exp_wb == 4'd1) chk("wrap_gwptr_lo", 32'(G_wptr), 32'(4'b0000));
    end

    // Settle, write five, then hit reset in the middle of the burst.
    W_INC  = 1'b0;
    G_rptr = b2g(exp_wb);
    tick();
    tick();
    W_INC = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("pre_rst_level", 32'(W_LEVEL), 32'd5);
    W_RST = 1'b1;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_en", 32'(W_EN), 32'd0);
    tick();
    #1;
    chk_idle("mid_rst_hold");
    chk("mid_rst_hold_en", 32'(W_EN), 32'd0);
`ifdef WR_OVF_FLAG_EN
    chk("mid_rst_ovf", 32'(W_OVF), 32'd0);
`endif
    W_INC  = 1'b0;
    G_rptr = 4'd0;
    tick();
    W_RST = 1'b0;
    #1;
    chk_idle("post_rst");
    W_INC = 1'b1;
    #1;
    chk("post_rst_en", 32'(W_EN), 32'd1);
    tick();
    #1;
    chk("post_rst_addr", 32'(W_addr), 32'd1);
    chk("post_rst_level", 32'(W_LEVEL), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
